csr_regfile: RTL
================

# csr_regfile

Architectural control/status register file for the dual-issue LA32R core, sitting directly downstream of the CSR pipeline register stage. It commits CSR software writes and exception/ERTN state updates presented in WB. It also runs the stable counter and the countdown timer, and produces the pending-interrupt signal consumed back in MEM as `MEM_interrupt`. Reads are combinational for the EX-stage CSR read path.

## Interface
- No parameters.
- `clk`  in  1  core clock
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `csr_raddr`  in  14  CSR read address (EX)
- `csr_rdata`  out  32  combinational read data
- `WB_csr_waddr`  in  14  CSR write address
- `WB_csr_we`  in  32  per-bit write mask (0 = no write)
- `WB_csr_wdata`  in  32  write data
- `WB_ecode_in`  in  7  [5:0] Ecode, [6] EsubCode bit 0
- `WB_ecode_we`  in  1  load ESTAT.Ecode/EsubCode
- `WB_badv_in` / `WB_badv_we`  in  32 / 1  BADV load
- `WB_era_in` / `WB_era_we`  in  32 / 1  ERA load
- `WB_store_state`  in  1  exception entry: save CRMD into PRMD
- `WB_restore_state`  in  1  ERTN: restore CRMD from PRMD
- `hw_int_in`  in  8  external interrupt lines, level
- `ipi_in`  in  1  inter-processor interrupt, level
- `interrupt`  out  1  pending enabled interrupt, to `MEM_interrupt`
- `eentry_pc`  out  32  `{EENTRY[31:6],6'b0}`
- `era_pc`  out  32  ERA value
- `crmd_plv`  out  2  current privilege level
- `rdcntv`  out  64  stable counter
- `rdcntid`  out  32  TID value

## Operation
- Write rule for every software-writable CSR: `new = (old & ~WB_csr_we) | (WB_csr_wdata & WB_csr_we)`, then non-writable bits are forced to their fixed value.
- CRMD 0x0: PLV[1:0], IE[2], DA[3]. Reset 0x0000_0008.
- PRMD 0x1: PPLV[1:0], PIE[2]. Reset 0.
- ECFG 0x4: LIE[12:0], bit 10 reads 0. Reset 0.
- ESTAT 0x5:
  - IS[1:0] software-writable.
  - IS[9:2] = `hw_int_in`, sampled every cycle.
  - IS[11] timer flag.
  - IS[12] = `ipi_in`, sampled.
  - Ecode[21:16], EsubCode[22].
  - Reset 0.
- ERA 0x6, BADV 0x7: full 32 bits. Reset 0.
- EENTRY 0xC: bits [31:6] writable. Reset 0.
- SAVE0-3 0x30-0x33: full 32 bits. TID 0x40: full 32 bits. Reset 0.
- TCFG 0x41: En[0], Periodic[1], InitVal[31:2]. Reset 0.
- TVAL 0x42: read-only. Reset 0.
- TICLR 0x44: reads 0. Writing bit 0 = 1 clears IS[11].
- Undefined addresses read 0; writes to them are ignored.
- `WB_store_state`:
  - PRMD.PPLV ← CRMD.PLV, PRMD.PIE ← CRMD.IE.
  - CRMD.PLV ← 0, CRMD.IE ← 0.
  - Takes priority over a same-cycle software write to CRMD/PRMD.
- `WB_restore_state`: CRMD.PLV ← PRMD.PPLV, CRMD.IE ← PRMD.PIE. Same priority as `WB_store_state`.
- `WB_ecode_we`, `WB_era_we`, `WB_badv_we` override same-cycle software writes to ESTAT.Ecode/EsubCode, ERA and BADV respectively.
- Timer uses an internal `armed` flag, reset 0.
  - Software write to TCFG with resulting En=1: TVAL ← `{InitVal,2'b00}`, armed ← 1.
  - Write with En=0: armed ← 0, TVAL holds its value.
  - Each cycle with En & armed & TVAL≠0: TVAL ← TVAL−1.
  - With En & armed & TVAL==0: IS[11] ← 1.
    - Periodic: TVAL reloads `{InitVal,2'b00}`.
    - Otherwise: armed ← 0 and TVAL ← 0xFFFF_FFFF (hold).
  - Timer set and a TICLR clear in the same cycle: the set wins.
- Stable counter: 64-bit, +1 every cycle, wraps 0xFFFF…F → 0. Reset 0.
- `interrupt` = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]). Combinational from registered state.

## Timing
- All state updates occur at the rising edge of `clk`.
- A WB write is visible on `csr_rdata` and on the derived outputs in the following cycle. There is no internal bypass; WB→EX forwarding belongs to the pipeline.
- `hw_int_in` / `ipi_in` to `interrupt`: 1-cycle latency (one sample register).
- Timer to `interrupt`: IS[11] is set at the edge where TVAL==0 is observed; `interrupt` goes high immediately after that edge.
- TCFG write at edge N:
  - TVAL = `{InitVal,00}` after N.
  - Zero is reached after edge N+`{InitVal,00}`.
  - IS[11] is set at the following edge.
- `rst` asserted at any cycle: all registers and `armed` return to reset values at that edge; the timer does not resume.

## Test plan
- Reset, then idle:
  - CRMD reads 0x8; ESTAT, TVAL and `interrupt` read 0.
  - `rdcntv` reads 0, 1, 2 on consecutive cycles.
- Masked write: SAVE0 = 0, `WB_csr_we` = 0x0000_FFFF, wdata = 0xDEAD_BEEF → SAVE0 reads 0x0000_BEEF next cycle.
- Exception entry with CRMD = 0x7, store_state=1, ecode 0x0B, era 0x1C00_0100 →
  - CRMD = 0x0, PRMD = 0x7, ESTAT[21:16] = 0x0B, `era_pc` = 0x1C00_0100.
  - A following restore_state → CRMD = 0x7.
  - A same-cycle software write of CRMD = 0x3 together with store_state → CRMD = 0x0.
- Periodic timer: CRMD.IE=1, LIE[11]=1, TCFG ← 0x13 →
  - TVAL = 0x10, then counts down to 0.
  - IS[11] set and `interrupt`=1 one edge after TVAL=0; TVAL reloads 0x10.
  - TICLR ← 1 → `interrupt`=0, unless it coincides with the next fire.
- One-shot timer: TCFG ← 0x9 →
  - Fires once; TVAL holds 0xFFFF_FFFF.
  - After TICLR, no second interrupt within 100 cycles.
- External interrupt: IE=1, LIE[2]=1, `hw_int_in`=0x01 → `interrupt`=1 one cycle later. With LIE[2]=0 → `interrupt` stays 0.

Source files
------------

// File: rtl/csr_regfile_if.sv
// CSR port bundle between the LA32R pipeline (EX read, WB commit) and the register file.
// The pipeline side drives the master modport and the register file uses the slave modport.
interface csr_regfile_if;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [13:0] WB_csr_waddr;
  logic [31:0] WB_csr_we;
  logic [31:0] WB_csr_wdata;
  logic [6:0]  WB_ecode_in;
  logic        WB_ecode_we;
  logic [31:0] WB_badv_in;
  logic        WB_badv_we;
  logic [31:0] WB_era_in;
  logic        WB_era_we;
  logic        WB_store_state;
  logic        WB_restore_state;
  logic [7:0]  hw_int_in;
  logic        ipi_in;
  logic        interrupt;
  logic [31:0] eentry_pc;
  logic [31:0] era_pc;
  logic [1:0]  crmd_plv;
  logic [63:0] rdcntv;
  logic [31:0] rdcntid;

  modport slave (
    input  csr_raddr, WB_csr_waddr, WB_csr_we, WB_csr_wdata,
    input  WB_ecode_in, WB_ecode_we, WB_badv_in, WB_badv_we, WB_era_in, WB_era_we,
    input  WB_store_state, WB_restore_state, hw_int_in, ipi_in,
    output csr_rdata, interrupt, eentry_pc, era_pc, crmd_plv, rdcntv, rdcntid
  );

  modport master (
    output csr_raddr, WB_csr_waddr, WB_csr_we, WB_csr_wdata,
    output WB_ecode_in, WB_ecode_we, WB_badv_in, WB_badv_we, WB_era_in, WB_era_we,
    output WB_store_state, WB_restore_state, hw_int_in, ipi_in,
    input  csr_rdata, interrupt, eentry_pc, era_pc, crmd_plv, rdcntv, rdcntid
  );
endinterface

// File: rtl/csr_regfile.sv
// LA32R architectural CSR file: WB commit of software/exception updates, stable counter,
// countdown timer and the pending-interrupt output. Reads are combinational.
module csr_regfile (
  input  logic          clk,
  input  logic          rst,
  csr_regfile_if.slave  bus
);

  localparam logic [13:0] A_CRMD   = 14'h000;
  localparam logic [13:0] A_PRMD   = 14'h001;
  localparam logic [13:0] A_ECFG   = 14'h004;
  localparam logic [13:0] A_ESTAT  = 14'h005;
  localparam logic [13:0] A_ERA    = 14'h006;
  localparam logic [13:0] A_BADV   = 14'h007;
  localparam logic [13:0] A_EENTRY = 14'h00C;
  localparam logic [13:0] A_SAVE0  = 14'h030;
  localparam logic [13:0] A_SAVE1  = 14'h031;
  localparam logic [13:0] A_SAVE2  = 14'h032;
  localparam logic [13:0] A_SAVE3  = 14'h033;
  localparam logic [13:0] A_TID    = 14'h040;
  localparam logic [13:0] A_TCFG   = 14'h041;
  localparam logic [13:0] A_TVAL   = 14'h042;
  localparam logic [13:0] A_TICLR  = 14'h044;

  logic [1:0]  crmd_plv, prmd_pplv;
  logic        crmd_ie, crmd_da, prmd_pie;
  logic [12:0] ecfg_lie;
  logic [1:0]  is_sw;
  logic [7:0]  is_hw;
  logic        is_ti, is_ipi;
  logic [5:0]  estat_ecode;
  logic        estat_esub;
  logic [31:0] era, badv;
  logic [25:0] eentry;
  logic [31:0] save0, save1, save2, save3, tid;
  logic [31:0] tcfg, tval;
  logic        armed;
  logic [63:0] stable_cnt;

  logic [31:0] we_m, wd_m, tcfg_nv;
  logic        wr_en, wr_tcfg, timer_fire;
  logic [12:0] is_vec;

  assign we_m    = bus.WB_csr_we;
  assign wd_m    = bus.WB_csr_wdata & bus.WB_csr_we;
  assign wr_en   = |bus.WB_csr_we;
  assign wr_tcfg = wr_en && (bus.WB_csr_waddr == A_TCFG);
  assign tcfg_nv = (tcfg & ~we_m) | wd_m;
  // A TCFG write in the same cycle re-programs the timer and suppresses the old terminal count.
  assign timer_fire = !wr_tcfg && tcfg[0] && armed && (tval == 32'd0);
  assign is_vec  = {is_ipi, is_ti, 1'b0, is_hw, is_sw};

  always_ff @(posedge clk) begin
    if (rst) begin
      crmd_plv    <= 2'd0;
      crmd_ie     <= 1'b0;
      crmd_da     <= 1'b1;
      prmd_pplv   <= 2'd0;
      prmd_pie    <= 1'b0;
      ecfg_lie    <= 13'd0;
      is_sw       <= 2'd0;
      is_hw       <= 8'd0;
      is_ti       <= 1'b0;
      is_ipi      <= 1'b0;
      estat_ecode <= 6'd0;
      estat_esub  <= 1'b0;
      era         <= 32'd0;
      badv        <= 32'd0;
      eentry      <= 26'd0;
      save0       <= 32'd0;
      save1       <= 32'd0;
      save2       <= 32'd0;
      save3       <= 32'd0;
      tid         <= 32'd0;
      tcfg        <= 32'd0;
      tval        <= 32'd0;
      armed       <= 1'b0;
      stable_cnt  <= 64'd0;
    end else begin
      stable_cnt <= stable_cnt + 64'd1;
      is_hw      <= bus.hw_int_in;
      is_ipi     <= bus.ipi_in;

      if (bus.WB_store_state) begin
        prmd_pplv <= crmd_plv;
        prmd_pie  <= crmd_ie;
        crmd_plv  <= 2'd0;
        crmd_ie   <= 1'b0;
      end else if (bus.WB_restore_state) begin
        crmd_plv <= prmd_pplv;
        crmd_ie  <= prmd_pie;
      end else if (wr_en) begin
        if (bus.WB_csr_waddr == A_CRMD) begin
          crmd_plv <= (crmd_plv & ~we_m[1:0]) | wd_m[1:0];
          crmd_ie  <= (crmd_ie  & ~we_m[2])   | wd_m[2];
          crmd_da  <= (crmd_da  & ~we_m[3])   | wd_m[3];
        end
        if (bus.WB_csr_waddr == A_PRMD) begin
          prmd_pplv <= (prmd_pplv & ~we_m[1:0]) | wd_m[1:0];
          prmd_pie  <= (prmd_pie  & ~we_m[2])   | wd_m[2];
        end
      end

      if (wr_en && bus.WB_csr_waddr == A_ECFG)
        ecfg_lie <= ((ecfg_lie & ~we_m[12:0]) | wd_m[12:0]) & 13'h1BFF;

      if (wr_en && bus.WB_csr_waddr == A_ESTAT)
        is_sw <= (is_sw & ~we_m[1:0]) | wd_m[1:0];

      if (bus.WB_ecode_we) begin
        estat_ecode <= bus.WB_ecode_in[5:0];
        estat_esub  <= bus.WB_ecode_in[6];
      end else if (wr_en && bus.WB_csr_waddr == A_ESTAT) begin
        estat_ecode <= (estat_ecode & ~we_m[21:16]) | wd_m[21:16];
        estat_esub  <= (estat_esub  & ~we_m[22])    | wd_m[22];
      end

      if (bus.WB_era_we)
        era <= bus.WB_era_in;
      else if (wr_en && bus.WB_csr_waddr == A_ERA)
        era <= (era & ~we_m) | wd_m;

      if (bus.WB_badv_we)
        badv <= bus.WB_badv_in;
      else if (wr_en && bus.WB_csr_waddr == A_BADV)
        badv <= (badv & ~we_m) | wd_m;

      if (wr_en) begin
        case (bus.WB_csr_waddr)
          A_EENTRY: eentry <= (eentry & ~we_m[31:6]) | wd_m[31:6];
          A_SAVE0:  save0  <= (save0 & ~we_m) | wd_m;
          A_SAVE1:  save1  <= (save1 & ~we_m) | wd_m;
          A_SAVE2:  save2  <= (save2 & ~we_m) | wd_m;
          A_SAVE3:  save3  <= (save3 & ~we_m) | wd_m;
          A_TID:    tid    <= (tid   & ~we_m) | wd_m;
          default: ;
        endcase
      end

      if (wr_tcfg) begin
        tcfg <= tcfg_nv;
        if (tcfg_nv[0]) begin
          tval  <= {tcfg_nv[31:2], 2'b00};
          armed <= 1'b1;
        end else begin
          armed <= 1'b0;
        end
      end else if (tcfg[0] && armed) begin
        if (tval != 32'd0) begin
          tval <= tval - 32'd1;
        end else if (tcfg[1]) begin
          tval <= {tcfg[31:2], 2'b00};
        end else begin
          armed <= 1'b0;
          tval  <= 32'hFFFF_FFFF;
        end
      end

      // Timer set beats a same-cycle TICLR clear.
      if (timer_fire)
        is_ti <= 1'b1;
      else if (wr_en && bus.WB_csr_waddr == A_TICLR && wd_m[0])
        is_ti <= 1'b0;
    end
  end

  always_comb begin
    bus.csr_rdata = 32'd0;
    case (bus.csr_raddr)
      A_CRMD:   bus.csr_rdata = {28'd0, crmd_da, crmd_ie, crmd_plv};
      A_PRMD:   bus.csr_rdata = {29'd0, prmd_pie, prmd_pplv};
      A_ECFG:   bus.csr_rdata = {19'd0, ecfg_lie};
      A_ESTAT:  bus.csr_rdata = {9'd0, estat_esub, estat_ecode, 3'd0, is_vec};
      A_ERA:    bus.csr_rdata = era;
      A_BADV:   bus.csr_rdata = badv;
      A_EENTRY: bus.csr_rdata = {eentry, 6'd0};
      A_SAVE0:  bus.csr_rdata = save0;
      A_SAVE1:  bus.csr_rdata = save1;
      A_SAVE2:  bus.csr_rdata = save2;
      A_SAVE3:  bus.csr_rdata = save3;
      A_TID:    bus.csr_rdata = tid;
      A_TCFG:   bus.csr_rdata = tcfg;
      A_TVAL:   bus.csr_rdata = tval;
      default:  bus.csr_rdata = 32'd0;
    endcase
  end

  assign bus.interrupt = crmd_ie & (|(is_vec & ecfg_lie));
  assign bus.eentry_pc = {eentry, 6'd0};
  assign bus.era_pc    = era;
  assign bus.crmd_plv  = crmd_plv;
  assign bus.rdcntv    = stable_cnt;
  assign bus.rdcntid   = tid;

endmodule
